// File: rtl/zynet_pkg.sv
// ============================================================================
// zynet_pkg : shared types and default sizes for the zyNet frame sequencer.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package zynet_pkg;

    localparam int ZN_WORD_SIZE      = 16;
    localparam int ZN_INPUT_SIZE     = 256;
    localparam int ZN_OUTPUT_SIZE    = 10;
    localparam int ZN_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_STREAM = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    typedef logic signed [ZN_WORD_SIZE-1:0] word_t;
    typedef word_t [ZN_OUTPUT_SIZE-1:0]     scores_t;

endpackage

`default_nettype wire

// File: rtl/frame_buffer.sv
// ============================================================================
// frame_buffer : register array, synchronous write port, combinational read.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module frame_buffer #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/inference_sequencer.sv
// ============================================================================
// inference_sequencer : buffers one host frame, bursts it into zyNet, waits
// (with watchdog) for class scores and presents them on a valid/yumi port.
// Optional macro ZYNET_ARGMAX_EN adds the argmax reduction onto class_o.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inference_sequencer
    import zynet_pkg::*;
#(
    parameter int WORD_SIZE      = ZN_WORD_SIZE,
    parameter int INPUT_SIZE     = ZN_INPUT_SIZE,
    parameter int OUTPUT_SIZE    = ZN_OUTPUT_SIZE,
    parameter int TIMEOUT_CYCLES = ZN_TIMEOUT_CYCLES
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [WORD_SIZE-1:0]             data_i,
    output logic                             net_start_o,
    output logic [WORD_SIZE-1:0]             net_data_o,
    input  logic                             net_valid_i,
    output logic                             net_yumi_o,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] net_data_i,
    output logic                             valid_o,
    input  logic                             yumi_i,
    output logic [OUTPUT_SIZE*WORD_SIZE-1:0] data_o,
    output logic [$clog2(OUTPUT_SIZE)-1:0]   class_o,
    output logic                             busy_o,
    output logic                             timeout_o
);

    localparam int c_addr_w = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int c_tmo_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(INPUT_SIZE - 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TIMEOUT_CYCLES - 1);

    state_t                           r_state;
    state_t                           w_next_state;
    logic [c_addr_w-1:0]              r_wr_cnt;
    logic [c_addr_w-1:0]              r_rd_cnt;
    logic [c_tmo_w-1:0]               r_tmo_cnt;
    logic [OUTPUT_SIZE*WORD_SIZE-1:0] r_data;
    logic                             r_timeout;
    logic                             w_wr_en;
    logic [WORD_SIZE-1:0]             w_buf_rdata;

    assign w_wr_en = (r_state == ST_LOAD) && valid_i;

    frame_buffer #(
        .DEPTH  (INPUT_SIZE),
        .WIDTH  (WORD_SIZE),
        .ADDR_W (c_addr_w)
    ) u_frame_buffer (
        .clk     (clk_i),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_cnt),
        .i_wdata (data_i),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_buf_rdata)
    );

`ifdef ZYNET_ARGMAX_EN
    localparam int c_idx_w = $clog2(OUTPUT_SIZE);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(OUTPUT_SIZE - 1);

    logic [c_idx_w-1:0]          r_idx;
    logic [c_idx_w-1:0]          r_best_idx;
    logic [c_idx_w-1:0]          r_class;
    logic signed [WORD_SIZE-1:0] r_best;
    logic signed [WORD_SIZE-1:0] w_score;
    logic                        w_take;

    // Index 0 always seeds the running best; strictly-greater keeps ties low.
    assign w_score = r_data[r_idx*WORD_SIZE +: WORD_SIZE];
    assign w_take  = (r_idx == '0) || (w_score > r_best);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best     <= '0;
            r_class    <= '0;
        end else if (r_state == ST_ARGMAX) begin
            if (w_take) begin
                r_best     <= w_score;
                r_best_idx <= r_idx;
            end
            if (r_idx == c_idx_last) begin
                r_idx   <= '0;
                r_class <= w_take ? r_idx : r_best_idx;
            end else begin
                r_idx <= r_idx + c_idx_w'(1);
            end
        end
    end

    assign class_o = r_class;
`else
    assign class_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (valid_i && (r_wr_cnt == c_last_addr)) w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_rd_cnt == c_last_addr) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (net_valid_i) begin
`ifdef ZYNET_ARGMAX_EN
                    w_next_state = ST_ARGMAX;
`else
                    w_next_state = ST_OUTPUT;
`endif
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_next_state = ST_LOAD;
                end
            end
`ifdef ZYNET_ARGMAX_EN
            ST_ARGMAX: begin
                if (r_idx == c_idx_last) w_next_state = ST_OUTPUT;
            end
`endif
            ST_OUTPUT: begin
                if (yumi_i) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_comb begin
        ready_o     = 1'b0;
        net_start_o = 1'b0;
        net_data_o  = '0;
        net_yumi_o  = 1'b0;
        valid_o     = 1'b0;
        busy_o      = (r_state != ST_LOAD);
        case (r_state)
            ST_LOAD:   ready_o = 1'b1;
            ST_STREAM: begin
                net_start_o = 1'b1;
                net_data_o  = w_buf_rdata;
            end
            ST_WAIT:   net_yumi_o = net_valid_i;
            ST_OUTPUT: valid_o = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_tmo_cnt <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (valid_i) begin
                        r_wr_cnt <= (r_wr_cnt == c_last_addr) ? '0 : r_wr_cnt + c_addr_w'(1);
                    end
                end
                ST_STREAM: begin
                    r_rd_cnt <= (r_rd_cnt == c_last_addr) ? '0 : r_rd_cnt + c_addr_w'(1);
                end
                ST_WAIT: begin
                    if (net_valid_i) begin
                        r_data    <= net_data_i;
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_tmo_cnt <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o    = r_data;
    assign timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_inference_sequencer.sv
// ============================================================================
// tb_inference_sequencer : scoreboard bench for inference_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inference_sequencer;
    import zynet_pkg::*;

    localparam int W   = 16;
    localparam int N   = 256;
    localparam int M   = 10;
    localparam int TMO = 8;
`ifdef ZYNET_ARGMAX_EN
    localparam bit ARG_ON  = 1'b1;
    localparam int EXP_LAT = M + 1;
`else
    localparam bit ARG_ON  = 1'b0;
    localparam int EXP_LAT = 1;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   data_i;
    logic           net_start_o;
    logic [W-1:0]   net_data_o;
    logic           net_valid_i;
    logic           net_yumi_o;
    logic [M*W-1:0] net_data_i;
    logic           valid_o;
    logic           yumi_i;
    logic [M*W-1:0] data_o;
    logic [3:0]     class_o;
    logic           busy_o;
    logic           timeout_o;

    inference_sequencer #(
        .WORD_SIZE      (W),
        .INPUT_SIZE     (N),
        .OUTPUT_SIZE    (M),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .net_start_o (net_start_o),
        .net_data_o  (net_data_o),
        .net_valid_i (net_valid_i),
        .net_yumi_o  (net_yumi_o),
        .net_data_i  (net_data_i),
        .valid_o     (valid_o),
        .yumi_i      (yumi_i),
        .data_o      (data_o),
        .class_o     (class_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int v_cyc    = 0;
    int burst_len = 0;
    bit prev_start = 1'b0;
    bit prev_valid = 1'b0;

    logic [W-1:0] sample_q[$];
    scores_t      exp_data_q[$];
    int           exp_class_q[$];

    task automatic check_value(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int ref_argmax(input scores_t s);
        int b = 0;
        for (int i = 1; i < M; i++) begin
            if (s[i] > s[b]) b = i;
        end
        return b;
    endfunction

    // Per-cycle scoreboard: push on host accept / network handoff, pop on DUT output.
    task automatic monitor_step();
        cyc++;
        if (reset_i) begin
            sample_q.delete();
            exp_data_q.delete();
            exp_class_q.delete();
            burst_len  = 0;
            prev_start = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (valid_i && ready_o) begin
                sample_q.push_back(data_i);
                last_acc = cyc;
            end
            if (net_start_o) begin
                if (!prev_start) check_value("burst_start", cyc, last_acc + 1);
                burst_len++;
                if (sample_q.size() == 0) check_value("stream_underrun", 1, 0);
                else check_value("stream_data", net_data_o, sample_q.pop_front());
            end else if (prev_start) begin
                check_value("burst_len", burst_len, N);
                burst_len = 0;
            end
            if (net_yumi_o) begin
                exp_data_q.push_back(scores_t'(net_data_i));
                exp_class_q.push_back(ARG_ON ? ref_argmax(scores_t'(net_data_i)) : 0);
                v_cyc = cyc;
            end
            if (valid_o && !prev_valid) begin
                if (exp_data_q.size() == 0) begin
                    check_value("unexpected_valid", 1, 0);
                end else begin
                    check_value("result_data", data_o, exp_data_q.pop_front());
                    check_value("result_class", class_o, exp_class_q.pop_front());
                    check_value("result_latency", cyc - v_cyc, EXP_LAT);
                end
            end
            prev_start = net_start_o;
            prev_valid = valid_o;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_value({tag, "_ready"}, ready_o, 1);
        check_value({tag, "_start"}, net_start_o, 0);
        check_value({tag, "_ndata"}, net_data_o, 0);
        check_value({tag, "_nyumi"}, net_yumi_o, 0);
        check_value({tag, "_valid"}, valid_o, 0);
        check_value({tag, "_data"}, data_o, 0);
        check_value({tag, "_class"}, class_o, 0);
        check_value({tag, "_busy"}, busy_o, 0);
        check_value({tag, "_timeout"}, timeout_o, 0);
    endtask

    task automatic send_frame(input int base, input bit gaps);
        int k = 0;
        int n = 0;
        bit tog = 1'b1;
        while (k < N && n < 4 * N) begin
            valid_i = gaps ? tog : 1'b1;
            tog     = !tog;
            data_i  = valid_i ? W'(base + k) : 16'hDEAD;
            if (gaps) check_value("ready_during_load", ready_o, 1);
            if (valid_i && ready_o) k++;
            step();
            n++;
        end
        valid_i = 1'b0;
        check_value("frame_loaded", k, N);
        check_value("ready_after_last", ready_o, 0);
    endtask

    task automatic wait_burst_end();
        int n = 0;
        while (!net_start_o && n < 10) begin step(); n++; end
        while (net_start_o && n < N + 20) begin step(); n++; end
        check_value("burst_ended", net_start_o, 0);
    endtask

    task automatic return_scores(input scores_t sc, input int exp_cls, input int hold);
        int n = 0;
        step();
        net_valid_i = 1'b1;
        net_data_i  = sc;
        step();
        net_valid_i = 1'b0;
        net_data_i  = '1;
        while (!valid_o && n < 40) begin step(); n++; end
        check_value("valid_seen", valid_o, 1);
        for (int i = 0; i < hold; i++) begin
            check_value("hold_valid", valid_o, 1);
            check_value("hold_data", data_o, sc);
            check_value("hold_class", class_o, exp_cls);
            step();
        end
        yumi_i = 1'b1;
        check_value("ready_in_output", ready_o, 0);
        step();
        yumi_i = 1'b0;
        check_value("valid_after_yumi", valid_o, 0);
        check_value("ready_after_yumi", ready_o, 1);
    endtask

    function automatic scores_t pack_scores(input int v[M]);
        scores_t s;
        for (int i = 0; i < M; i++) s[i] = word_t'(v[i]);
        return s;
    endfunction

    initial begin
        int sv[M];
        scores_t sc_a, sc_b, sc_c;
        sv = '{3, -5, 9, 9, 0, 0, 0, 0, 0, 0};
        sc_a = pack_scores(sv);
        sv = '{-7, -3, -3, -9, -100, -20, -3, -8, -32768, -5};
        sc_b = pack_scores(sv);
        sv = '{-32768, 100, 5, 100, 0, 0, 0, 0, 0, 32767};
        sc_c = pack_scores(sv);

        reset_i = 1'b1; valid_i = 1'b0; data_i = '0;
        net_valid_i = 1'b0; net_data_i = '0; yumi_i = 1'b0;
        @(posedge clk_i); #1;
        step();
        check_reset("por");
        reset_i = 1'b0;
        step();

        send_frame(0, 1'b0);
        wait_burst_end();
        return_scores(sc_a, ARG_ON ? 2 : 0, 20);

        send_frame(0, 1'b1);
        wait_burst_end();
        return_scores(sc_b, ARG_ON ? 1 : 0, 2);

        send_frame(16'h1234, 1'b0);
        wait_burst_end();
        for (int i = 0; i < TMO; i++) begin
            check_value("tmo_busy", busy_o, 1);
            check_value("tmo_flag_low", timeout_o, 0);
            step();
        end
        check_value("tmo_back_to_load", busy_o, 0);
        check_value("tmo_flag", timeout_o, 1);
        check_value("tmo_ready", ready_o, 1);
        check_value("tmo_no_valid", valid_o, 0);

        send_frame(16'h8000, 1'b0);
        wait_burst_end();
        return_scores(sc_c, ARG_ON ? 9 : 0, 2);
        check_value("tmo_sticky", timeout_o, 1);

        send_frame(16'h0100, 1'b0);
        for (int i = 0; i < 50; i++) step();
        check_value("mid_stream", net_start_o, 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_reset("mid_rst");

        send_frame(0, 1'b0);
        wait_burst_end();
        return_scores(sc_a, ARG_ON ? 2 : 0, 2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inference_sequencer.md
# inference_sequencer

- Frame-level controller in front of the zyNet datapath.
- Accepts one input frame of INPUT_SIZE samples from a host stream and buffers it.
- Replays the frame into the network as one contiguous start burst.
- Waits for the network's class scores with a watchdog, optionally reduces them to an argmax class index, and presents the result on a valid/yumi interface.
- It is the only block that drives the network's start and data inputs.

## Interface
- WORD_SIZE, 16, bits per sample/score (signed two's complement)
- INPUT_SIZE, 256, samples per frame
- OUTPUT_SIZE, 10, class scores per result
- TIMEOUT_CYCLES, 65535, max cycles spent in WAIT before abort
- clk_i  in  1  clock, all logic rising-edge
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  1  host sample valid
- ready_o  out  1  sequencer can accept a sample
- data_i  in  WORD_SIZE  host sample
- net_start_o  out  1  network start/strobe, high for the whole burst
- net_data_o  out  WORD_SIZE  sample to network
- net_valid_i  in  1  network result valid
- net_yumi_o  out  1  network result consumed
- net_data_i  in  OUTPUT_SIZE×WORD_SIZE  network scores
- valid_o  out  1  result available
- yumi_i  in  1  consumer takes result
- data_o  out  OUTPUT_SIZE×WORD_SIZE  captured scores
- class_o  out  $clog2(OUTPUT_SIZE)  argmax index
- busy_o  out  1  state ≠ LOAD
- timeout_o  out  1  sticky watchdog error

## Operation
States:
- **LOAD:** ready_o=1. Each valid_i&ready_o writes data_i to buf[wr_cnt] and increments wr_cnt. Accepting word INPUT_SIZE-1 clears wr_cnt and moves to STREAM.
- **STREAM:** net_start_o=1, net_data_o=buf[rd_cnt] (combinational read of a register array), rd_cnt increments every cycle with no stall. After INPUT_SIZE cycles, clear rd_cnt and move to WAIT.
- **WAIT:** net_yumi_o=net_valid_i. On net_valid_i, latch net_data_i into data_o, clear tmo_cnt, and move to ARGMAX. Otherwise tmo_cnt increments. When tmo_cnt==TIMEOUT_CYCLES-1 with no net_valid_i: set timeout_o, discard the frame, return to LOAD.
- **ARGMAX:** Walks idx 0..OUTPUT_SIZE-1, one score per cycle. Signed compare, strictly-greater replaces the best score, so ties keep the lowest index. After the last index, class_o is written and the state moves to OUTPUT.
- **OUTPUT:** valid_o=1, data_o and class_o held stable. When yumi_i=1, return to LOAD.

Rules:
- net_valid_i outside WAIT is ignored; net_yumi_o=0 in all other states.
- yumi_i outside OUTPUT is ignored.
- timeout_o is cleared only by reset.
- Reset at any time: state LOAD, all counters 0, frame discarded.

## Timing
- Reset values: ready_o=1, net_start_o=0, net_data_o=0, net_yumi_o=0, valid_o=0, data_o=0, class_o=0, busy_o=0, timeout_o=0.
- Last sample accepted in cycle t: net_start_o is high in cycles t+1 … t+INPUT_SIZE, with sample k in cycle t+1+k.
- ready_o falls in cycle t+1. No sample is accepted again until LOAD is re-entered.
- net_valid_i in WAIT at cycle v:
  - With argmax: valid_o rises at v+1+OUTPUT_SIZE.
  - Without argmax: valid_o rises at v+1.
- valid_o and yumi_i both high at cycle u: valid_o=0 and ready_o=1 at u+1.
- A new frame's first sample can be accepted at u+1.

## Configuration
- Macro: ZYNET_ARGMAX_EN.
- Defined: the ARGMAX state and its comparator/index logic are compiled in, and class_o carries the argmax.
- Undefined: the ARGMAX state is absent, WAIT goes directly to OUTPUT, and class_o is tied to 0.

## Structure
- **Shared package zynet_pkg:**
  - state enum (LOAD, STREAM, WAIT, ARGMAX, OUTPUT)
  - word_t (signed WORD_SIZE)
  - scores_t (packed OUTPUT_SIZE array of word_t)
- **Sub-module frame_buffer:** INPUT_SIZE×WORD_SIZE register array with synchronous write port and combinational read port. It is instantiated once.

## Test plan
- Reset, then stream samples 0..255 with valid_i held high → net_start_o high for exactly 256 cycles. net_data_o equals 0..255 in order, and the burst starts one cycle after the last accept.
- Host valid_i toggling 1/0 every cycle → buffer contents and burst order are identical to the no-gap case, and ready_o drops only after the 256th accept.
- Scores {3,-5,9,9,0,…} returned one cycle into WAIT → data_o equals the scores, class_o=2 (tie goes to the lower index), and valid_o rises 11 cycles after net_valid_i.
- yumi_i held low for 20 cycles in OUTPUT → valid_o, data_o and class_o remain stable. yumi_i=1 → ready_o=1 on the next cycle.
- TIMEOUT_CYCLES=8 and net_valid_i never asserted → after 8 WAIT cycles timeout_o=1 (sticky), state returns to LOAD, and valid_o is never asserted.
- reset_i pulsed mid-STREAM → next cycle all outputs are at reset values (including timeout_o=0), and the next frame streams correctly from sample 0.
